// File: rtl/matrix_loader.sv
// Stream loader for matrix_mult operands: accepts N*N elements of A then N*N of B
// (row-major) into zero-padded MAX_SIZE x MAX_SIZE arrays, then flags them valid.
module matrix_loader #(
   parameter int MAX_SIZE = 16,
   parameter int DATA_W   = 32,
   parameter int NW       = $clog2(MAX_SIZE) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NW-1:0]     cfg_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] A [0:MAX_SIZE-1][0:MAX_SIZE-1],
   output logic [DATA_W-1:0] B [0:MAX_SIZE-1][0:MAX_SIZE-1],
   output logic [NW-1:0]     n_out,
   output logic              busy,
   output logic              done,
   output logic              mats_valid,
   output logic              err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD_A = 2'd1;
   localparam logic [1:0] LOAD_B = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [NW-1:0] MAX_N = NW'(MAX_SIZE);
   localparam logic [NW-1:0] ONE   = NW'(1);

   logic [1:0]        state_reg, state_next;
   logic [NW-1:0]     row_reg, col_reg, n_reg;
   logic              mv_reg, err_reg;
   logic [DATA_W-1:0] a_reg [0:MAX_SIZE-1][0:MAX_SIZE-1];
   logic [DATA_W-1:0] b_reg [0:MAX_SIZE-1][0:MAX_SIZE-1];

   logic          start_ok, start_bad, xfer, last, wr_a, wr_b;
   logic [NW-1:0] n_last;

   assign in_ready   = (state_reg == LOAD_A) || (state_reg == LOAD_B);
   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign mats_valid = mv_reg;
   assign err        = err_reg;
   assign n_out      = n_reg;
   assign A          = a_reg;
   assign B          = b_reg;

   assign start_ok  = (state_reg == IDLE) && start && (cfg_n != '0) && (cfg_n <= MAX_N);
   assign start_bad = (state_reg == IDLE) && start && !start_ok;
   assign xfer      = in_valid && in_ready;
   assign n_last    = n_reg - ONE;
   assign last      = (row_reg == n_last) && (col_reg == n_last);
   assign wr_a      = xfer && (state_reg == LOAD_A);
   assign wr_b      = xfer && (state_reg == LOAD_B);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_ok) state_next = LOAD_A;
         LOAD_A:  if (xfer && last) state_next = LOAD_B;
         LOAD_B:  if (xfer && last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         row_reg   <= '0;
         col_reg   <= '0;
         n_reg     <= '0;
         mv_reg    <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= start_bad;
         if (start_ok) begin
            n_reg   <= cfg_n;
            mv_reg  <= 1'b0;
            row_reg <= '0;
            col_reg <= '0;
         end else if (xfer) begin
            // The (N-1,N-1) transfer wraps both counters, ready for B or the next load.
            if (col_reg == n_last) begin
               col_reg <= '0;
               row_reg <= last ? '0 : row_reg + ONE;
            end else begin
               col_reg <= col_reg + ONE;
            end
         end
         if (wr_b && last) mv_reg <= 1'b1;
      end
   end

   // Per-element storage: a whole-array clear on start gives the zero padding.
   genvar gi, gj;
   generate
      for (gi = 0; gi < MAX_SIZE; gi++) begin : g_row
         for (gj = 0; gj < MAX_SIZE; gj++) begin : g_col
            logic hit;
            assign hit = (row_reg == NW'(gi)) && (col_reg == NW'(gj));
            always_ff @(posedge clk) begin
               if (!rst || start_ok) begin
                  a_reg[gi][gj] <= '0;
                  b_reg[gi][gj] <= '0;
               end else if (hit) begin
                  if (wr_a) a_reg[gi][gj] <= in_data;
                  if (wr_b) b_reg[gi][gj] <= in_data;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: drivers queue expected done/err events,
// a negedge monitor pops and checks them against a row-major reference model.
module tb_matrix_loader;
   localparam int MS = 16;
   localparam int NW = $clog2(MS) + 1;
   localparam int K_DONE = 0;
   localparam int K_ERR  = 1;

   typedef logic [31:0] mat_t [0:MS-1][0:MS-1];

   logic clk, rst, start, in_valid, in_ready, busy, done, mats_valid, err;
   logic [NW-1:0] cfg_n, n_out;
   logic [31:0] in_data;
   mat_t a_out, b_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   int exp_kind[$];
   int exp_cyc[$];
   int exp_nq[$];
   logic [31:0] exp_el[$];
   logic [31:0] stim[$];

   mat_t mdl_a, mdl_b;
   int mdl_n;
   logic mdl_mv;

   matrix_loader #(.MAX_SIZE(MS), .DATA_W(32), .NW(NW)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .A(a_out), .B(b_out), .n_out(n_out), .busy(busy), .done(done),
      .mats_valid(mats_valid), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic chk_mat(input string nm, input mat_t act, input mat_t expv);
      int br, bc;
      br = -1;
      bc = -1;
      for (int r = MS - 1; r >= 0; r--)
         for (int c = MS - 1; c >= 0; c--)
            if (act[r][c] !== expv[r][c]) begin
               br = r;
               bc = c;
            end
      total++;
      if (br >= 0) begin
         bad++;
         $display("FAIL %s: [%0d][%0d] got %h expected %h", nm, br, bc,
                  act[br][bc], expv[br][bc]);
      end
   endtask

   task automatic zero_mat(output mat_t m);
      for (int r = 0; r < MS; r++)
         for (int c = 0; c < MS; c++)
            m[r][c] = '0;
   endtask

   task automatic chk_reset_state(input string tag);
      mat_t z;
      zero_mat(z);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_mats_valid"}, mats_valid, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_n_out"}, n_out, 0);
      chk_mat({tag, "_A"}, a_out, z);
      chk_mat({tag, "_B"}, b_out, z);
   endtask

   // Monitor: every done/err pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      mat_t ea, eb;
      int c, n;
      if (rst) begin
         if (done) begin
            if (exp_kind.size() == 0 || exp_kind[0] != K_DONE) begin
               total++;
               bad++;
               $display("FAIL done_unexpected: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               void'(exp_kind.pop_front());
               c = exp_cyc.pop_front();
               n = exp_nq.pop_front();
               for (int r = 0; r < MS; r++)
                  for (int cc = 0; cc < MS; cc++)
                     ea[r][cc] = exp_el.pop_front();
               for (int r = 0; r < MS; r++)
                  for (int cc = 0; cc < MS; cc++)
                     eb[r][cc] = exp_el.pop_front();
               chk("done_cycle", cyc, c);
               chk("mats_valid_at_done", mats_valid, 1);
               chk("n_out_at_done", n_out, n);
               chk_mat("A_at_done", a_out, ea);
               chk_mat("B_at_done", b_out, eb);
               $display("done n=%0d at cycle %0d (expected %0d)", n, cyc, c);
            end
         end
         if (err) begin
            if (exp_kind.size() == 0 || exp_kind[0] != K_ERR) begin
               total++;
               bad++;
               $display("FAIL err_unexpected: got err=1 expected no err (cycle %0d)", cyc);
            end else begin
               void'(exp_kind.pop_front());
               c = exp_cyc.pop_front();
               void'(exp_nq.pop_front());
               chk("err_cycle", cyc, c);
               $display("err at cycle %0d (expected %0d)", cyc, c);
            end
         end
      end
   end

   function automatic bit is_gap(input int t, input int gap_every);
      return (gap_every > 0) && ((t % gap_every) == gap_every - 1);
   endfunction

   // One load of size n; optional valid gaps, a stray start at cycle busy_at,
   // or a reset at cycle rst_at (which abandons the load).
   task automatic do_load(input int n, input int gap_every, input int busy_at, input int rst_at);
      logic [31:0] el[$];
      mat_t ea, eb;
      int ne, gaps, k, se;
      bit aborted;
      ne = 2 * n * n;
      el = {};
      for (int i = 0; i < ne; i++)
         el.push_back((i < stim.size()) ? stim[i] : $urandom);
      stim = {};
      zero_mat(ea);
      zero_mat(eb);
      for (int i = 0; i < n * n; i++) begin
         ea[i / n][i % n] = el[i];
         eb[i / n][i % n] = el[n * n + i];
      end
      gaps = 0;
      k = 0;
      for (int t = 0; k < ne; t++)
         if (is_gap(t, gap_every)) gaps++;
         else k++;

      @(posedge clk); #1;
      start = 1'b1;
      cfg_n = NW'(n);
      se = cyc + 1;
      if (rst_at < 0) begin
         exp_kind.push_back(K_DONE);
         exp_cyc.push_back(se + ne + gaps);
         exp_nq.push_back(n);
         for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
               exp_el.push_back(ea[r][c]);
         for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
               exp_el.push_back(eb[r][c]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("in_ready_after_start", in_ready, 1);
      chk("mats_valid_during_load", mats_valid, 0);
      chk("n_out_after_start", n_out, n);

      k = 0;
      aborted = 1'b0;
      for (int t = 0; k < ne && !aborted; t++) begin
         if (t == rst_at) begin
            rst = 1'b0;
            in_valid = 1'b0;
            start = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            aborted = 1'b1;
            chk_reset_state("midload_reset");
            zero_mat(mdl_a);
            zero_mat(mdl_b);
            mdl_n = 0;
            mdl_mv = 1'b0;
         end else begin
            start = (t == busy_at);
            cfg_n = (t == busy_at) ? NW'(3) : NW'(n);
            if (is_gap(t, gap_every)) begin
               in_valid = 1'b0;
               in_data = $urandom;
            end else begin
               in_valid = 1'b1;
               in_data = el[k];
               k++;
            end
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (!aborted) begin
         @(posedge clk); #1;
         chk("busy_after_done", busy, 0);
         chk("in_ready_after_done", in_ready, 0);
         chk("done_single_pulse", done, 0);
         chk("mats_valid_held", mats_valid, 1);
         mdl_a = ea;
         mdl_b = eb;
         mdl_n = n;
         mdl_mv = 1'b1;
         $display("load n=%0d gaps=%0d started edge %0d", n, gaps, se);
      end else begin
         $display("load n=%0d aborted by reset", n);
      end
   endtask

   task automatic bad_start(input int bad_n);
      int se;
      @(posedge clk); #1;
      start = 1'b1;
      cfg_n = NW'(bad_n);
      se = cyc + 1;
      exp_kind.push_back(K_ERR);
      exp_cyc.push_back(se);
      exp_nq.push_back(0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_bad_start", busy, 0);
      chk("in_ready_after_bad_start", in_ready, 0);
      @(posedge clk); #1;
      chk("err_single_pulse", err, 0);
      chk("n_out_kept", n_out, mdl_n);
      chk("mats_valid_kept", mats_valid, mdl_mv);
      chk_mat("A_kept", a_out, mdl_a);
      chk_mat("B_kept", b_out, mdl_b);
      $display("bad start cfg_n=%0d issued edge %0d", bad_n, se);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      cfg_n = '0;
      in_data = '0;
      in_valid = 1'b0;
      zero_mat(mdl_a);
      zero_mat(mdl_b);
      mdl_n = 0;
      mdl_mv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b1;

      for (int i = 0; i < 8; i++) stim.push_back(32'(i + 1));
      do_load(2, 0, -1, -1);
      bad_start(0);
      bad_start(MS + 1);
      do_load(MS, 3, -1, -1);
      do_load(4, 0, -1, -1);
      stim = {32'd7, 32'd9};
      do_load(1, 0, -1, -1);
      do_load(2, 0, 3, -1);
      do_load(2, 0, -1, 6);
      do_load(2, 0, -1, -1);
      do_load(3, 2, -1, -1);
      bad_start(MS + 5);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_kind.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for `matrix_mult`. It accepts a row-major stream of 32-bit elements: first the N×N elements of A, then the N×N elements of B. It writes them into MAX_SIZE×MAX_SIZE operand arrays, with every element outside the N×N corner zero-padded. When both matrices are complete it signals that the operands are valid. It replaces file-based operand loading, so a host or DMA can drive the multiplier through a valid/ready stream.

## Interface
Parameters:
- MAX_SIZE, 16, maximum matrix dimension; must match the downstream `matrix_mult`.
- DATA_W, 32, element width.
- NW, $clog2(MAX_SIZE)+1, width of the size field.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a load; samples cfg_n in the same cycle.
- cfg_n  in  NW  matrix size N for this load.
- in_data  in  DATA_W  stream element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts an element this cycle.
- A  out  DATA_W × [0:MAX_SIZE-1][0:MAX_SIZE-1]  operand A array, drives `matrix_mult.A`.
- B  out  DATA_W × [0:MAX_SIZE-1][0:MAX_SIZE-1]  operand B array, drives `matrix_mult.B`.
- n_out  out  NW  N of the most recently accepted load.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when the final B element has been stored.
- mats_valid  out  1  A and B hold a complete operand set.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, DONE.
- Transfer rule: a transfer occurs only when in_valid && in_ready.
- in_ready equals 1 in LOAD_A and LOAD_B, and 0 in all other states. It is derived from registered state only, with no combinational path from in_valid.
- IDLE, start with 1 ≤ cfg_n ≤ MAX_SIZE:
  - latch N into n_out;
  - clear every element of A and B to 0;
  - clear mats_valid;
  - reset row/col counters to 0;
  - move to LOAD_A.
- IDLE, start with cfg_n = 0 or cfg_n > MAX_SIZE:
  - pulse err;
  - stay in IDLE;
  - leave A, B, n_out and mats_valid unchanged.
- LOAD_A: each transfer writes A[row][col] and advances the counters.
  - col counts 0..N-1, then wraps to 0 and row increments.
  - The transfer at (N-1, N-1) resets the counters and moves to LOAD_B.
- LOAD_B: same as LOAD_A, but writes B. The transfer at (N-1, N-1) moves to DONE.
- DONE: lasts one cycle. done = 1, mats_valid is set to 1, then the FSM returns to IDLE.
- Start while busy (LOAD_A, LOAD_B or DONE): ignored. No err, and no effect on the load in progress.
- Counters are NW bits wide and compare against the latched N, not MAX_SIZE.
- Zero padding is guaranteed because the whole array is cleared on start, before any element is written.
- Reset (rst = 0 on a rising edge) returns the block to its initial state from any state, including mid-load. Partial data is discarded.
- Reset values of outputs:
  - A and B: all 0;
  - n_out = 0;
  - in_ready = 0, busy = 0, done = 0, mats_valid = 0, err = 0;
  - state = IDLE.

## Timing
- Start accepted at edge k: busy = 1 and in_ready = 1 from cycle k+1.
- Throughput is one element per cycle.
- There is no bubble between A and B: the last A transfer and the first B transfer can be in adjacent cycles.
- With in_valid held at 1 and start at edge 0:
  - transfers occur at edges 1..2N²;
  - done = 1 in the cycle after edge 2N²;
  - mats_valid = 1 from that same cycle;
  - busy = 0 in the cycle after done.
- Gaps in in_valid stall the counters and FSM. Latency extends by exactly the number of idle cycles.
- err is asserted in the cycle after the rejected start.
- Array writes become visible on the outputs the cycle after the transfer.
- mats_valid stays 1 until the next accepted start or a reset.

## Test plan
- **N=2 load.** Stream A = 1,2,3,4 and B = 5,6,7,8 with in_valid held high, start at cycle 0.
  - A[0][0..1] = 1,2 and A[1][0..1] = 3,4; B[0][0..1] = 5,6 and B[1][0..1] = 7,8.
  - All other elements are 0.
  - done at cycle 9, n_out = 2.
  - The downstream `matrix_mult` then yields C = 19,22 / 43,50.
- **N=MAX_SIZE with valid gaps.** Drive in_valid low on every third cycle across all 512 elements.
  - Every element lands at its row-major position.
  - done arrives exactly 512 + (number of gap cycles) cycles after start.
- **Reload with a smaller N.** Load N=4 with nonzero data, then N=1 with A = 7, B = 9.
  - A[0][0] = 7 and B[0][0] = 9.
  - Every other element is 0; no leftover N=4 data remains.
  - mats_valid is 0 during the second load.
- **Bad sizes.** start with cfg_n = 0, then with cfg_n = MAX_SIZE+1.
  - err pulses once for each start; busy stays 0.
  - Arrays, n_out and mats_valid are unchanged.
- **Start while busy.** Issue start with cfg_n = 3 during an N=2 load.
  - The start is ignored and err stays 0.
  - The N=2 load completes normally with n_out = 2.
- **Reset mid-load.** Pull rst low for one cycle during LOAD_B.
  - All outputs return to their reset values and in_ready = 0.
  - A subsequent N=2 load completes correctly.
